// File: rtl/watch_pkg.sv
// Shared definitions for the watch display path.
//   mode_e      : FSM mode encodings as driven on state_in
//   DIG_*       : scan/edit digit indices, 0 = leftmost (hours tens)
//   SEG_BLANK   : all segments off (active-low)
//   SEG_DASH    : middle bar only, shown for non-BCD values
//   bcd_to_seg  : BCD to {g,f,e,d,c,b,a} active-low segment pattern
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  localparam logic [1:0] DIG_HH_T = 2'd0;
  localparam logic [1:0] DIG_HH_U = 2'd1;
  localparam logic [1:0] DIG_MM_T = 2'd2;
  localparam logic [1:0] DIG_MM_U = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/watch_display_scan_if.sv
// Connection between the watch FSM (master) and the display scanner (slave).
//   state_in   : FSM mode (watch_pkg::mode_e encoding)
//   edit_digit : digit under edit in the set modes
//   hh_*/mm_*  : time BCD digits
//   ah_*/am_*  : alarm BCD digits
//   sw_*       : stopwatch mm:ss BCD digits
//   an/seg/dp  : active-low display drive produced by the scanner
interface watch_display_scan_if;
  logic [1:0] state_in;
  logic [1:0] edit_digit;
  logic [3:0] hh_t, hh_u, mm_t, mm_u;
  logic [3:0] ah_t, ah_u, am_t, am_u;
  logic [3:0] sw_mt, sw_mu, sw_st, sw_su;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output state_in, edit_digit,
    output hh_t, hh_u, mm_t, mm_u,
    output ah_t, ah_u, am_t, am_u,
    output sw_mt, sw_mu, sw_st, sw_su,
    input  an, seg, dp
  );

  modport slave (
    input  state_in, edit_digit,
    input  hh_t, hh_u, mm_t, mm_u,
    input  ah_t, ah_u, am_t, am_u,
    input  sw_mt, sw_mu, sw_st, sw_su,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i : 4-bit digit; 10-15 decode to a dash
//   seg_o : {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/watch_display_scan.sv
// Four-digit common-anode 7-segment scanner for the watch.
// Drives one digit at a time for SCAN_DIV cycles, selecting time, alarm or stopwatch digits
// by mode, blinking the edited digit in the set modes and driving the colon on the hours-units DP.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : watch_display_scan_if.slave (FSM digits/mode in, an/seg/dp out, all registered)
// Build option: define WATCH_DISP_LZB_EN for leading-zero blanking of digit 0 in NORMAL and
// STOPWATCH modes.
module watch_display_scan
  import watch_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input logic                 clk,
  input logic                 rst,
  watch_display_scan_if.slave bus
);

  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned FrameW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_DIV - 1);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [1:0]        state_prev_q, edit_prev_q;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  mode_e      mode;
  logic       scan_wrap, frame_wrap, restart, blink_eff;
  logic       set_mode, blank_edit, lz_blank;
  logic [15:0] src;
  logic [3:0]  digit_sel;
  logic [6:0]  dec_seg;

  assign mode = mode_e'(bus.state_in);

  // Scan position and blink timebase.
  always_comb begin
    scan_wrap   = (scan_cnt_q == ScanLast);
    frame_wrap  = scan_wrap && (idx_q == DIG_MM_U);
    restart     = (bus.state_in != state_prev_q) || (bus.edit_digit != edit_prev_q);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
    idx_d       = scan_wrap ? idx_q + 2'd1 : idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (restart) begin
      frame_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FrameW'(1);
      end
    end
    // A mode/field change shows the new field lit from its very first output cycle.
    blink_eff = restart ? 1'b0 : blink_ph_q;
  end

  // Source and digit mux, packed leftmost digit first.
  always_comb begin
    src = {bus.hh_t, bus.hh_u, bus.mm_t, bus.mm_u};
    case (mode)
      MODE_NORMAL, MODE_SET_TIME: src = {bus.hh_t, bus.hh_u, bus.mm_t, bus.mm_u};
      MODE_SET_ALARM:             src = {bus.ah_t, bus.ah_u, bus.am_t, bus.am_u};
      MODE_STOPWATCH:             src = {bus.sw_mt, bus.sw_mu, bus.sw_st, bus.sw_su};
      default:                    src = {bus.hh_t, bus.hh_u, bus.mm_t, bus.mm_u};
    endcase
    case (idx_q)
      DIG_HH_T: digit_sel = src[15:12];
      DIG_HH_U: digit_sel = src[11:8];
      DIG_MM_T: digit_sel = src[7:4];
      default:  digit_sel = src[3:0];
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd_i (digit_sel),
    .seg_o (dec_seg)
  );

  // Output stage: anode, segment override and colon.
  always_comb begin
    set_mode   = (mode == MODE_SET_TIME) || (mode == MODE_SET_ALARM);
    blank_edit = set_mode && blink_eff && (idx_q == bus.edit_digit);
`ifdef WATCH_DISP_LZB_EN
    lz_blank   = (idx_q == DIG_HH_T) && (digit_sel == 4'd0) &&
                 ((mode == MODE_NORMAL) || (mode == MODE_STOPWATCH));
`else
    lz_blank   = 1'b0;
`endif
    an_d  = ~(4'b1000 >> idx_q);
    seg_d = (blank_edit || lz_blank) ? SEG_BLANK : dec_seg;
    dp_d  = 1'b1;
    if (idx_q == DIG_HH_U) begin
      case (mode)
        MODE_NORMAL:    dp_d = blink_eff;
        MODE_STOPWATCH: dp_d = 1'b0;
        default:        dp_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      state_prev_q <= '0;
      edit_prev_q  <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      state_prev_q <= bus.state_in;
      edit_prev_q  <= bus.edit_digit;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
